fpu_job_sequencer: RTL and testbench

//  Queues FP jobs {opcode,a,b}, issues each to one fpu engine over its start/done handshake
//  (engine clear pulse first), captures {z,error} into a result queue, with timeout/flush/stats.

---
 rtl/fpu_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/fpu_job_sequencer.sv | 179 +++++++++++++++++
 tb/tb_fpu_job_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU opcodes, error codes and sequencer state encoding
package fpu_pkg;

  localparam int OPW_DEF  = 2;
  localparam int ERRW_DEF = 3;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [2:0] ERR_NONE     = 3'b000;
  localparam logic [2:0] ERR_INVALID  = 3'b001;
  localparam logic [2:0] ERR_OVERFLOW = 3'b010;
  localparam logic [2:0] ERR_DIVZERO  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLR   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_STORE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - valid/ready synchronous FIFO with synchronous flush
// Head data reads as zero while empty so downstream outputs stay clean.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_valid_i,
  output logic         push_ready_o,
  input  logic [W-1:0] push_data_i,
  output logic         pop_valid_o,
  input  logic         pop_ready_i,
  output logic [W-1:0] pop_data_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         full, empty, do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_valid_i && !full && !flush_i;
  assign do_pop  = pop_ready_i && !empty && !flush_i;

  assign push_ready_o = !full;
  assign pop_valid_o  = !empty;
  assign pop_data_o   = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/fpu_job_sequencer.sv
// rtl/fpu_job_sequencer.sv - queues FP jobs, drives one engine via clr/start/done, queues results
// A result slot is reserved at dispatch, so the result FIFO can never overflow.
module fpu_job_sequencer
  import fpu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int OPW     = OPW_DEF,
  parameter int ERRW    = ERRW_DEF,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255,
  parameter int CNTW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic [ERRW-1:0]  out_error,
  output logic             out_tmo,
  output logic             fpu_clr,
  output logic             fpu_start,
  output logic [OPW-1:0]   fpu_opcode,
  output logic [WIDTH-1:0] fpu_a,
  output logic [WIDTH-1:0] fpu_b,
  input  logic [WIDTH-1:0] fpu_z,
  input  logic [ERRW-1:0]  fpu_error,
  input  logic             fpu_done,
  output logic             busy,
  output logic [CNTW-1:0]  ops_cnt,
  output logic [CNTW-1:0]  err_cnt
);

  localparam int JW  = OPW + 2 * WIDTH;
  localparam int RW  = WIDTH + ERRW + 1;
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT - 1);

  seq_state_e       state_q, state_d;
  logic             alive_q;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, z_q, z_d;
  logic [ERRW-1:0]  err_q, err_d;
  logic             tmo_q, tmo_d;
  logic [TCW-1:0]   tcnt_q, tcnt_d;
  logic [CNTW-1:0]  ops_q, ops_d, errc_q, errc_d;

  logic          job_ready, job_valid, job_pop, res_slot, res_push;
  logic [JW-1:0] job_data;

  // in_ready stays low for the first cycle after reset release.
  assign in_ready = job_ready && alive_q && !flush;

  sync_fifo #(.W(JW), .DEPTH(DEPTH)) u_job_fifo (
    .clk          (clk),
    .rst_n        (rst),
    .flush_i      (flush),
    .push_valid_i (in_valid && in_ready),
    .push_ready_o (job_ready),
    .push_data_i  ({in_opcode, in_a, in_b}),
    .pop_valid_o  (job_valid),
    .pop_ready_i  (job_pop),
    .pop_data_o   (job_data)
  );

  sync_fifo #(.W(RW), .DEPTH(DEPTH)) u_res_fifo (
    .clk          (clk),
    .rst_n        (rst),
    .flush_i      (flush),
    .push_valid_i (res_push),
    .push_ready_o (res_slot),
    .push_data_i  ({z_q, err_q, tmo_q}),
    .pop_valid_o  (out_valid),
    .pop_ready_i  (out_ready),
    .pop_data_o   ({out_z, out_error, out_tmo})
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    z_d       = z_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    tcnt_d    = tcnt_q;
    ops_d     = ops_q;
    errc_d    = errc_q;
    job_pop   = 1'b0;
    res_push  = 1'b0;
    fpu_clr   = 1'b0;
    fpu_start = 1'b0;
    if (flush) begin
      // Abort: clear the engine only if an op was actually in flight.
      state_d = ST_IDLE;
      fpu_clr = (state_q != ST_IDLE);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (job_valid && res_slot) begin
            job_pop            = 1'b1;
            {op_d, a_d, b_d}   = job_data;
            state_d            = ST_CLR;
          end
        end
        ST_CLR: begin
          fpu_clr = 1'b1;
          tcnt_d  = '0;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          fpu_start = 1'b1;
          if (fpu_done) begin
            z_d     = fpu_z;
            err_d   = fpu_error;
            tmo_d   = 1'b0;
            state_d = ST_STORE;
          end else if (tcnt_q == TMO_LAST) begin
            z_d     = '0;
            err_d   = '0;
            tmo_d   = 1'b1;
            state_d = ST_STORE;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        ST_STORE: begin
          res_push = 1'b1;
          ops_d    = (ops_q == {CNTW{1'b1}}) ? ops_q : ops_q + 1'b1;
          if ((err_q != '0) || tmo_q)
            errc_d = (errc_q == {CNTW{1'b1}}) ? errc_q : errc_q + 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      alive_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      err_q   <= '0;
      tmo_q   <= 1'b0;
      tcnt_q  <= '0;
      ops_q   <= '0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      tcnt_q  <= tcnt_d;
      ops_q   <= ops_d;
      errc_q  <= errc_d;
    end
  end

  assign fpu_opcode = op_q;
  assign fpu_a      = a_q;
  assign fpu_b      = b_q;
  assign busy       = (state_q != ST_IDLE);
  assign ops_cnt    = ops_q;
  assign err_cnt    = errc_q;

endmodule

// File: tb/tb_fpu_job_sequencer.sv
// tb/tb_fpu_job_sequencer.sv - directed self-checking bench for fpu_job_sequencer
// A small reactive engine model answers start with done after model_lat cycles.
module tb_fpu_job_sequencer;
  import fpu_pkg::*;

  localparam int WIDTH = 32, OPW = 2, ERRW = 3, DEPTH = 8, TIMEOUT = 20, CNTW = 16;

  logic clk, rst, flush, in_valid, in_ready, out_valid, out_ready, out_tmo;
  logic [OPW-1:0] in_opcode, fpu_opcode;
  logic [WIDTH-1:0] in_a, in_b, out_z, fpu_a, fpu_b, fpu_z;
  logic [ERRW-1:0] out_error, fpu_error;
  logic fpu_clr, fpu_start, fpu_done, busy;
  logic [CNTW-1:0] ops_cnt, err_cnt;

  int assert_cnt = 0;
  int fail_cnt = 0;
  int start_cyc = 0;
  int clr_cyc = 0;

  logic model_hang, ovr_en;
  logic [31:0] ovr_z;
  int model_lat;
  int m_cnt;

  fpu_job_sequencer #(.WIDTH(WIDTH), .OPW(OPW), .ERRW(ERRW), .DEPTH(DEPTH),
                      .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_error(out_error),
    .out_tmo(out_tmo), .fpu_clr(fpu_clr), .fpu_start(fpu_start), .fpu_opcode(fpu_opcode),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_z(fpu_z), .fpu_error(fpu_error), .fpu_done(fpu_done),
    .busy(busy), .ops_cnt(ops_cnt), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpu_done <= 1'b0; fpu_z <= '0; fpu_error <= '0; m_cnt <= 0;
    end else if (fpu_clr || !fpu_start) begin
      fpu_done <= 1'b0; m_cnt <= 0;
    end else if (!fpu_done) begin
      m_cnt <= m_cnt + 1;
      if (!model_hang && (m_cnt + 1 >= model_lat)) begin
        fpu_done  <= 1'b1;
        fpu_z     <= ovr_en ? ovr_z : (fpu_a ^ {fpu_b[15:0], fpu_b[31:16]});
        fpu_error <= (fpu_opcode == OP_DIV && fpu_b == '0) ? 3'b100 : 3'b000;
      end
    end
  end

  always @(negedge clk) begin
    if (fpu_start) start_cyc++;
    if (fpu_clr) clr_cyc++;
  end

  task automatic push_job(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b;
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    assert_cnt++;
    if (!in_ready) begin
      fail_cnt++;
      $display("FAIL push_accept: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pop_result(output logic [31:0] z, output logic [2:0] e, output logic t,
                            output logic ok);
    int n = 0;
    while (!out_valid && n < 400) begin @(negedge clk); n++; end
    ok = out_valid; z = out_z; e = out_error; t = out_tmo;
    if (ok) begin out_ready = 1'b1; @(negedge clk); out_ready = 1'b0; end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    assert_cnt++;
    if ({in_ready, out_valid, fpu_clr, fpu_start, busy} !== 5'b0) begin
      fail_cnt++;
      $display("FAIL reset_ctrl: {in_ready,out_valid,clr,start,busy}=%b required 00000",
               {in_ready, out_valid, fpu_clr, fpu_start, busy});
    end
    assert_cnt++;
    if ({ops_cnt, err_cnt, out_z, fpu_a} !== '0) begin
      fail_cnt++;
      $display("FAIL reset_data: ops=%0d err=%0d z=%h a=%h required all 0",
               ops_cnt, err_cnt, out_z, fpu_a);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    logic [31:0] z; logic [2:0] e; logic t, ok; int s0, c0;
    model_lat = 4; ovr_en = 1'b1; ovr_z = 32'h40400000;
    s0 = start_cyc; c0 = clr_cyc;
    push_job(OP_ADD, 32'h3F800000, 32'h40000000);
    pop_result(z, e, t, ok);
    ovr_en = 1'b0;
    assert_cnt++;
    if ({ok, z, e, t} !== {1'b1, 32'h40400000, 3'b000, 1'b0}) begin
      fail_cnt++;
      $display("FAIL single_result: ok=%b z=%h err=%b tmo=%b required 1 40400000 000 0", ok, z, e, t);
    end
    assert_cnt++;
    if (ops_cnt !== 16'd1 || err_cnt !== 16'd0) begin
      fail_cnt++;
      $display("FAIL single_cnt: ops=%0d err=%0d required 1 0", ops_cnt, err_cnt);
    end
    assert_cnt++;
    if (start_cyc - s0 != 5 || clr_cyc - c0 != 1) begin
      fail_cnt++;
      $display("FAIL single_handshake: start_cycles=%0d clr_cycles=%0d required 5 1",
               start_cyc - s0, clr_cyc - c0);
    end
  endtask

  task automatic test_error();
    logic [31:0] z; logic [2:0] e; logic t, ok;
    model_lat = 2;
    push_job(OP_DIV, 32'h3F800000, 32'h00000000);
    pop_result(z, e, t, ok);
    assert_cnt++;
    if ({ok, z, e, t} !== {1'b1, 32'h3F800000, 3'b100, 1'b0}) begin
      fail_cnt++;
      $display("FAIL div0_result: ok=%b z=%h err=%b tmo=%b required 1 3f800000 100 0", ok, z, e, t);
    end
    assert_cnt++;
    if (ops_cnt !== 16'd2 || err_cnt !== 16'd1) begin
      fail_cnt++;
      $display("FAIL div0_cnt: ops=%0d err=%0d required 2 1", ops_cnt, err_cnt);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] z; logic [2:0] e; logic t, ok; int s0;
    model_hang = 1'b1;
    s0 = start_cyc;
    push_job(OP_MUL, 32'h00000001, 32'h00000002);
    pop_result(z, e, t, ok);
    model_hang = 1'b0;
    assert_cnt++;
    if ({ok, z, e, t} !== {1'b1, 32'h0, 3'b000, 1'b1}) begin
      fail_cnt++;
      $display("FAIL tmo_result: ok=%b z=%h err=%b tmo=%b required 1 00000000 000 1", ok, z, e, t);
    end
    assert_cnt++;
    if (start_cyc - s0 != TIMEOUT) begin
      fail_cnt++;
      $display("FAIL tmo_wait_cycles: got %0d required %0d", start_cyc - s0, TIMEOUT);
    end
    assert_cnt++;
    if (ops_cnt !== 16'd3 || err_cnt !== 16'd2) begin
      fail_cnt++;
      $display("FAIL tmo_cnt: ops=%0d err=%0d required 3 2", ops_cnt, err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] z, ez; logic [2:0] e; logic t, ok;
    model_lat = 1;
    for (int i = 0; i < 9; i++) push_job(OP_ADD, 32'h1000 + i, 32'h0);
    repeat (80) @(negedge clk);
    assert_cnt++;
    if ({busy, out_valid, in_ready} !== 3'b011) begin
      fail_cnt++;
      $display("FAIL b2b_stall: {busy,out_valid,in_ready}=%b required 011", {busy, out_valid, in_ready});
    end
    for (int i = 9; i < 16; i++) push_job(OP_ADD, 32'h1000 + i, 32'h0);
    assert_cnt++;
    if (in_ready !== 1'b0) begin
      fail_cnt++;
      $display("FAIL b2b_job_full: in_ready=%b required 0", in_ready);
    end
    for (int i = 0; i < 16; i++) begin
      ez = 32'h1000 + i;
      pop_result(z, e, t, ok);
      assert_cnt++;
      if ({ok, z, e, t} !== {1'b1, ez, 3'b000, 1'b0}) begin
        fail_cnt++;
        $display("FAIL b2b_order[%0d]: ok=%b z=%h err=%b tmo=%b required 1 %h 000 0", i, ok, z, e, t, ez);
      end
    end
    assert_cnt++;
    if (ops_cnt !== 16'd19 || err_cnt !== 16'd2) begin
      fail_cnt++;
      $display("FAIL b2b_cnt: ops=%0d err=%0d required 19 2", ops_cnt, err_cnt);
    end
  endtask

  task automatic test_flush();
    int n = 0;
    model_hang = 1'b0; model_lat = 1;
    push_job(OP_ADD, 32'h5, 32'h0);
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    model_hang = 1'b1;
    for (int i = 0; i < 4; i++) push_job(OP_SUB, i, i);
    n = 0;
    while (!fpu_start && n < 50) begin @(negedge clk); n++; end
    assert_cnt++;
    if ({out_valid, fpu_start} !== 2'b11) begin
      fail_cnt++;
      $display("FAIL flush_setup: {out_valid,start}=%b required 11", {out_valid, fpu_start});
    end
    flush = 1'b1;
    #1;
    assert_cnt++;
    if ({fpu_clr, in_ready} !== 2'b10) begin
      fail_cnt++;
      $display("FAIL flush_pulse: {clr,in_ready}=%b required 10", {fpu_clr, in_ready});
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    assert_cnt++;
    if ({busy, out_valid, fpu_clr} !== 3'b000) begin
      fail_cnt++;
      $display("FAIL flush_after: {busy,out_valid,clr}=%b required 000", {busy, out_valid, fpu_clr});
    end
    repeat (30) @(negedge clk);
    assert_cnt++;
    if ({busy, out_valid, fpu_start, in_ready} !== 4'b0001) begin
      fail_cnt++;
      $display("FAIL flush_empty: {busy,out_valid,start,in_ready}=%b required 0001",
               {busy, out_valid, fpu_start, in_ready});
    end
    assert_cnt++;
    if (ops_cnt !== 16'd20 || err_cnt !== 16'd2) begin
      fail_cnt++;
      $display("FAIL flush_cnt: ops=%0d err=%0d required 20 2", ops_cnt, err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] z; logic [2:0] e; logic t, ok; int n = 0;
    model_hang = 1'b1;
    push_job(OP_ADD, 32'h7, 32'h0);
    while (!fpu_start && n < 50) begin @(negedge clk); n++; end
    rst = 1'b0;
    #1;
    assert_cnt++;
    if ({fpu_clr, fpu_start, busy, in_ready, out_valid} !== 5'b0 || fpu_a !== '0) begin
      fail_cnt++;
      $display("FAIL rstmid_ctrl: {clr,start,busy,in_ready,out_valid}=%b a=%h required 00000 0",
               {fpu_clr, fpu_start, busy, in_ready, out_valid}, fpu_a);
    end
    assert_cnt++;
    if (ops_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      fail_cnt++;
      $display("FAIL rstmid_cnt: ops=%0d err=%0d required 0 0", ops_cnt, err_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_hang = 1'b0; model_lat = 2;
    push_job(OP_ADD, 32'h12345678, 32'h0000ABCD);
    pop_result(z, e, t, ok);
    assert_cnt++;
    if ({ok, z, e, t} !== {1'b1, 32'hB9F95678, 3'b000, 1'b0} || ops_cnt !== 16'd1) begin
      fail_cnt++;
      $display("FAIL rstmid_next: ok=%b z=%h err=%b tmo=%b ops=%0d required 1 b9f95678 000 0 1",
               ok, z, e, t, ops_cnt);
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0;
    out_ready = 1'b0; model_hang = 1'b0; model_lat = 4; ovr_en = 1'b0; ovr_z = '0;
    test_reset();
    test_single();
    test_error();
    test_timeout();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
